apb_csr_ctrl: RTL

APB slave controller that sequences the CSR register bank built from `d_ff` byte registers. It decodes APB transfers into one-hot write-enable pulses and latched write data for the bank. It returns read data through a registered read path with configurable wait states. It sits between the APB bus and the `d_ff` instances; it holds no CSR contents itself.

---
 rtl/apb_csr_pkg.sv | 13 +
 rtl/apb_csr_addr_dec.sv | 28 ++
 rtl/apb_csr_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/apb_csr_pkg.sv
// rtl/apb_csr_pkg.sv - shared state encodings and constants for the APB CSR controller
package apb_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] RO_MASK_DEFAULT = 8'h80;
    localparam int         CNT_W           = 4;

endpackage

// File: rtl/apb_csr_addr_dec.sv
// rtl/apb_csr_addr_dec.sv - combinational register-index decode: one-hot select, out-of-range and read-only flags
module apb_csr_addr_dec
    import apb_csr_pkg::*;
#(
    parameter int                    ADDR_W   = 4,
    parameter int                    NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK  = RO_MASK_DEFAULT
) (
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [NUM_REGS-1:0] sel_o,
    output logic                oor_o,
    output logic                ro_hit_o
);

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_i == ADDR_W'(i)) begin
                sel_o[i] = 1'b1;
            end
        end
    end

    // No select bit means the index lies beyond the bank.
    assign oor_o    = ~|sel_o;
    assign ro_hit_o = |(sel_o & RO_MASK);

endmodule

// File: rtl/apb_csr_ctrl.sv
// rtl/apb_csr_ctrl.sv - APB slave sequencing a d_ff CSR bank; APB_CSR_SLVERR_EN enables pslverr on invalid accesses
module apb_csr_ctrl
    import apb_csr_pkg::*;
#(
    parameter int                  ADDR_W      = 4,
    parameter int                  DATA_W      = 8,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_CYCLES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = RO_MASK_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_psel,
    input  logic                       i_penable,
    input  logic                       i_pwrite,
    input  logic [ADDR_W-1:0]          i_paddr,
    input  logic [DATA_W-1:0]          i_pwdata,
    output logic                       o_pready,
    output logic [DATA_W-1:0]          o_prdata,
    output logic                       o_pslverr,
    output logic [NUM_REGS-1:0]        o_reg_en,
    output logic [DATA_W-1:0]          o_reg_wdata,
    input  logic [NUM_REGS*DATA_W-1:0] i_reg_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic                bad_q, bad_d;
    logic [NUM_REGS-1:0] sel_q, sel_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [NUM_REGS-1:0] dec_sel;
    logic                dec_oor;
    logic                dec_ro;
    logic                setup;
    logic                cur_write;
    logic                cur_bad;
    logic [NUM_REGS-1:0] cur_sel;
    logic [DATA_W-1:0]   rd_slice;
    logic                enter_done;

    apb_csr_addr_dec #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) u_addr_dec (
        .addr_i   (i_paddr),
        .sel_o    (dec_sel),
        .oor_o    (dec_oor),
        .ro_hit_o (dec_ro)
    );

    assign setup = i_psel & ~i_penable;

    // A zero-wait transfer completes straight out of IDLE, so use the live decode there.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_write = i_pwrite;
            cur_sel   = dec_sel;
            cur_bad   = dec_oor | (i_pwrite & dec_ro);
        end else begin
            cur_write = write_q;
            cur_sel   = sel_q;
            cur_bad   = bad_q;
        end
    end

    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cur_sel[i]) begin
                rd_slice = rd_slice | i_reg_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        sel_d   = sel_q;
        bad_d   = bad_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    write_d = i_pwrite;
                    sel_d   = dec_sel;
                    bad_d   = cur_bad;
                    wdata_d = i_pwdata;
                    if (i_pwrite || WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_psel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_done = (state_d == ST_DONE);

    always_comb begin
        pready_d = enter_done;
        reg_en_d = (enter_done && cur_write && !cur_bad) ? cur_sel : '0;
        prdata_d = prdata_q;
        if (enter_done && !cur_write) begin
            prdata_d = cur_bad ? '0 : rd_slice;
        end
`ifdef APB_CSR_SLVERR_EN
        pslverr_d = enter_done & cur_bad;
`else
        pslverr_d = 1'b0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            sel_q     <= '0;
            bad_q     <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            reg_en_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            sel_q     <= sel_d;
            bad_q     <= bad_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            reg_en_q  <= reg_en_d;
        end
    end

    assign o_pready    = pready_q;
    assign o_pslverr   = pslverr_q;
    assign o_prdata    = prdata_q;
    assign o_reg_en    = reg_en_q;
    assign o_reg_wdata = wdata_q;

endmodule
